// File: rtl/alu_seq_divider.sv
// alu_seq_divider: radix-2 restoring divider for RISC-V DIV/DIVU/REM/REMU
// with zero-divisor and signed-overflow fast paths.
module alu_seq_divider #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   input  logic            kill,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            busy
);
   localparam int CW = $clog2(XLEN) + 1;
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t          state;
   logic [CW-1:0]   cnt;
   logic [XLEN-1:0] rem_q, quo_q, dvs_q;
   logic            is_rem, neg_q, neg_r;
   logic            is_signed, a_neg, b_neg, ovf, div_zero, ge;
   logic [XLEN-1:0] a_mag, b_mag, rem_nx, quo_nx, fin, fast;
   logic [XLEN:0]   sh, diff;
   assign is_signed = ~op[0];
   assign a_neg     = is_signed & dividend[XLEN-1];
   assign b_neg     = is_signed & divisor[XLEN-1];
   assign a_mag     = a_neg ? -dividend : dividend;
   assign b_mag     = b_neg ? -divisor : divisor;
   assign div_zero  = divisor == '0;
   assign ovf       = is_signed && dividend == {1'b1, {(XLEN-1){1'b0}}} && &divisor;
   // zero divisor: quotient all-ones, remainder is the dividend; overflow: quotient is the dividend
   assign fast      = div_zero ? (op[1] ? dividend : '1) : (op[1] ? '0 : dividend);
   assign sh        = {rem_q, quo_q[XLEN-1]};
   assign diff      = sh - {1'b0, dvs_q};
   assign ge        = ~diff[XLEN];
   assign rem_nx    = ge ? diff[XLEN-1:0] : sh[XLEN-1:0];
   assign quo_nx    = {quo_q[XLEN-2:0], ge};
   assign fin       = is_rem ? (neg_r ? -rem_nx : rem_nx) : (neg_q ? -quo_nx : quo_nx);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         cnt       <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvs_q     <= '0;
         is_rem    <= 1'b0;
         neg_q     <= 1'b0;
         neg_r     <= 1'b0;
         result    <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else if (kill) begin
         state     <= IDLE;
         result    <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               is_rem   <= op[1];
               neg_q    <= a_neg ^ b_neg;
               neg_r    <= a_neg;
               quo_q    <= a_mag;
               dvs_q    <= b_mag;
               rem_q    <= '0;
               cnt      <= '0;
               in_ready <= 1'b0;
               busy     <= 1'b1;
               if (div_zero || ovf) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  result    <= fast;
               end else begin
                  state <= CALC;
               end
            end
            CALC: begin
               rem_q <= rem_nx;
               quo_q <= quo_nx;
               cnt   <= cnt + 1'b1;
               if (cnt == CW'(XLEN - 1)) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  result    <= fin;
               end
            end
            DONE: if (out_ready) begin
               state     <= IDLE;
               result    <= '0;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_seq_divider.sv
// tb_alu_seq_divider: directed vectors with a queue scoreboard checked by a
// monitor on the falling edge.
module tb_alu_seq_divider;
   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [1:0]  op = 2'b00;
   logic [31:0] dividend = '0;
   logic [31:0] divisor = '0;
   logic        kill = 1'b0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] result;
   logic        busy;
   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   bit          mon_en = 1'b0;
   bit          prev_ov = 1'b0;
   typedef struct {
      logic [31:0] exp;
      int          lat;
      int          acc;
      string       nm;
   } exp_t;
   exp_t sb[$];

   alu_seq_divider #(.XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .dividend(dividend), .divisor(divisor), .kill(kill),
      .out_valid(out_valid), .out_ready(out_ready), .result(result), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // monitor: every output cycle is compared against the head of the scoreboard
   always @(negedge clk) if (mon_en) begin
      if (!out_valid) begin
         chk("zero_when_invalid", result, 32'h0);
      end else if (sb.size() == 0) begin
         chk("unexpected_valid", {31'b0, out_valid}, 32'h0);
      end else begin
         if (!prev_ov) chk({"lat_", sb[0].nm}, 32'(cyc - sb[0].acc), 32'(sb[0].lat));
         chk(sb[0].nm, result, sb[0].exp);
         if (out_ready) void'(sb.pop_front());
      end
      prev_ov = out_valid;
   end

   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int lat, input string nm, input bit push);
      int n = 0;
      while (!in_ready && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      chk({"ready_", nm}, {31'b0, in_ready}, 32'h1);
      op = o; dividend = a; divisor = b; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      dividend = $urandom; divisor = $urandom; op = 2'($urandom);
      if (push) sb.push_back('{exp, lat, cyc, nm});
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 2000) begin
         @(posedge clk); #1;
         n++;
      end
      chk("drain", 32'(sb.size()), 32'h0);
   endtask

   initial begin
      #2 rst_n = 1'b0;
      #1;
      chk("rst_in_ready", {31'b0, in_ready}, 32'h1);
      chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
      chk("rst_busy", {31'b0, busy}, 32'h0);
      chk("rst_result", result, 32'h0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      mon_en = 1'b1;
      issue(2'b01, 32'd100, 32'd7, 32'd14, 32, "divu_100_7", 1'b1);
      issue(2'b11, 32'd100, 32'd7, 32'd2, 32, "remu_100_7", 1'b1);
      issue(2'b00, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32, "div_m7_2", 1'b1);
      issue(2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32, "rem_m7_2", 1'b1);
      issue(2'b10, 32'd7, 32'hFFFFFFFE, 32'd1, 32, "rem_7_m2", 1'b1);
      issue(2'b00, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14, 32, "div_m100_m7", 1'b1);
      issue(2'b10, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32, "rem_m100_m7", 1'b1);
      issue(2'b00, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 32, "div_100_m7", 1'b1);
      issue(2'b01, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32, "divu_min_ones", 1'b1);
      issue(2'b01, 32'h1234, 32'h0, 32'hFFFFFFFF, 0, "divu_by0", 1'b1);
      issue(2'b11, 32'h1234, 32'h0, 32'h1234, 0, "remu_by0", 1'b1);
      issue(2'b00, 32'hFFFFFF9C, 32'h0, 32'hFFFFFFFF, 0, "div_by0", 1'b1);
      issue(2'b10, 32'hFFFFFF9C, 32'h0, 32'hFFFFFF9C, 0, "rem_by0", 1'b1);
      issue(2'b00, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, "div_ovf", 1'b1);
      issue(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h0, 0, "rem_ovf", 1'b1);
      drain();
      // held result with back-pressure, then handshake edge must not accept
      out_ready = 1'b0;
      issue(2'b01, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32, "divu_stall", 1'b1);
      for (int n = 0; n < 100 && !out_valid; n++) begin
         @(posedge clk); #1;
      end
      for (int i = 0; i < 5; i++) begin
         chk("stall_in_ready", {31'b0, in_ready}, 32'h0);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      in_valid = 1'b1; op = 2'b01; dividend = 32'd20; divisor = 32'd4;
      @(posedge clk); #1;
      chk("hs_busy", {31'b0, busy}, 32'h0);
      chk("hs_in_ready", {31'b0, in_ready}, 32'h1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      sb.push_back('{32'd5, 32, cyc, "divu_after_hs"});
      chk("after_hs_busy", {31'b0, busy}, 32'h1);
      drain();
      // kill together with in_valid in IDLE is not an acceptance
      kill = 1'b1; in_valid = 1'b1; op = 2'b01; dividend = 32'd8; divisor = 32'd2;
      @(posedge clk); #1;
      kill = 1'b0; in_valid = 1'b0;
      chk("kill_idle_busy", {31'b0, busy}, 32'h0);
      // kill on the 10th CALC edge
      issue(2'b01, 32'd1000, 32'd3, 32'd0, 32, "killed", 1'b0);
      repeat (9) @(posedge clk);
      #1 kill = 1'b1;
      @(posedge clk); #1;
      kill = 1'b0;
      chk("kill_in_ready", {31'b0, in_ready}, 32'h1);
      chk("kill_out_valid", {31'b0, out_valid}, 32'h0);
      chk("kill_busy", {31'b0, busy}, 32'h0);
      repeat (40) @(posedge clk);
      #1;
      issue(2'b01, 32'd9, 32'd3, 32'd3, 32, "divu_9_3", 1'b1);
      drain();
      // reset mid-CALC aborts, then accept on the first edge after release
      issue(2'b01, 32'd5000, 32'd7, 32'd0, 32, "reset_abort", 1'b0);
      repeat (5) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_in_ready", {31'b0, in_ready}, 32'h1);
      chk("midrst_out_valid", {31'b0, out_valid}, 32'h0);
      chk("midrst_busy", {31'b0, busy}, 32'h0);
      chk("midrst_result", result, 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      in_valid = 1'b1; op = 2'b01; dividend = 32'd9; divisor = 32'd3;
      @(posedge clk); #1;
      in_valid = 1'b0;
      sb.push_back('{32'd3, 32, cyc, "divu_post_rst"});
      chk("post_rst_busy", {31'b0, busy}, 32'h1);
      drain();
      repeat (3) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      errors++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "timeout");
   end
endmodule
